// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, write-read bypass
// into the captured operands, and a saturating count of inserted bubbles.
//
// Handshake: there is no valid/ready pair here. An instruction advances from
// ID into EX on a rising clk only when flush, stall and load_use_stall are all
// low. A flush or a load-use hazard replaces the EX contents with a bubble
// (all zeros). A stall freezes EX completely.
module id_ex_stage #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_read_data1,
   input  logic [XLEN-1:0] id_read_data2,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [7:0]      id_ctrl,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_op1,
   output logic [XLEN-1:0] ex_op2,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [7:0]      ex_ctrl,
   output logic            load_use_stall,
   output logic [31:0]     bubble_count
);

   localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

   logic            insert_bubble;
   logic [XLEN-1:0] op1_next;
   logic [XLEN-1:0] op2_next;

   // Hazard detect: a load in EX whose destination is a source of the ID
   // instruction. Register 0 is compared like any other index.
   always_comb begin
      load_use_stall = ex_valid & ex_ctrl[1] & id_valid &
                       ((ex_rd == id_rs1) | (ex_rd == id_rs2));
   end

   // A bubble is written on flush, or on a load-use hazard that is not
   // overridden by an external stall.
   always_comb begin
      insert_bubble = flush | (~stall & load_use_stall);
   end

   // Write-read bypass: the register file writes and reads in the same
   // cycle, so a matching write must replace the stale read data.
   always_comb begin
      op1_next = id_read_data1;
      op2_next = id_read_data2;
      if (wb_reg_write && (wb_rd == id_rs1)) begin
         op1_next = wb_data;
      end
      if (wb_reg_write && (wb_rd == id_rs2)) begin
         op2_next = wb_data;
      end
   end

   // EX pipeline register: flush/bubble clears, stall holds, otherwise load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         ex_pc    <= '0;
         ex_op1   <= '0;
         ex_op2   <= '0;
         ex_imm   <= '0;
         ex_rs1   <= '0;
         ex_rs2   <= '0;
         ex_rd    <= '0;
      end else if (insert_bubble) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         ex_pc    <= '0;
         ex_op1   <= '0;
         ex_op2   <= '0;
         ex_imm   <= '0;
         ex_rs1   <= '0;
         ex_rs2   <= '0;
         ex_rd    <= '0;
      end else if (!stall) begin
         ex_valid <= id_valid;
         ex_ctrl  <= id_valid ? id_ctrl : 8'h00;
         ex_pc    <= id_pc;
         ex_op1   <= op1_next;
         ex_op2   <= op2_next;
         ex_imm   <= id_imm;
         ex_rs1   <= id_rs1;
         ex_rs2   <= id_rs2;
         ex_rd    <= id_rd;
      end
   end

   // Bubble counter: one step per inserted bubble, pinned at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bubble_count <= '0;
      end else if (insert_bubble && (bubble_count != COUNT_MAX)) begin
         bubble_count <= bubble_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a table of ID-side vectors with the expected
// EX-side result of each, pushed to an expected queue when driven and
// compared one edge later, plus hand-written reset and saturation sequences.
module tb_id_ex_stage;

   localparam int XLEN = 64;
   localparam int EW   = 1 + 8 + 4 * XLEN + 15 + 32;
   localparam int NV   = 20;

   typedef enum logic [1:0] {K_LD, K_BUB, K_HOLD} kind_t;

   typedef struct {
      logic        st;
      logic        fl;
      logic        v;
      logic [63:0] pc;
      logic [4:0]  rs1;
      logic [63:0] rd1;
      logic [4:0]  rs2;
      logic [63:0] rd2;
      logic [63:0] imm;
      logic [4:0]  rd;
      logic [7:0]  ctrl;
      logic        we;
      logic [4:0]  wrd;
      logic [63:0] wdata;
      kind_t       kind;
      logic [63:0] op1;
      logic [63:0] op2;
      logic        lus;
      logic [31:0] bc;
   } vec_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            stall, flush, id_valid;
   logic [XLEN-1:0] id_pc, id_read_data1, id_read_data2, id_imm;
   logic [4:0]      id_rs1, id_rs2, id_rd;
   logic [7:0]      id_ctrl;
   logic            wb_reg_write;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc, ex_op1, ex_op2, ex_imm;
   logic [4:0]      ex_rs1, ex_rs2, ex_rd;
   logic [7:0]      ex_ctrl;
   logic            load_use_stall;
   logic [31:0]     bubble_count;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] last_exp;
   vec_t          tv[NV];
   int            n_cmp  = 0;
   int            n_fail = 0;

   id_ex_stage #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_read_data1(id_read_data1),
      .id_read_data2(id_read_data2), .id_imm(id_imm), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
      .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_ctrl(ex_ctrl), .load_use_stall(load_use_stall),
      .bubble_count(bubble_count)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, expected end of test");
      $fatal(1, "watchdog");
   end

   function automatic vec_t row(
      input logic st, input logic fl, input logic v, input logic [63:0] pc,
      input logic [4:0] rs1, input logic [63:0] rd1,
      input logic [4:0] rs2, input logic [63:0] rd2,
      input logic [63:0] imm, input logic [4:0] rd, input logic [7:0] ctrl,
      input logic we, input logic [4:0] wrd, input logic [63:0] wdata,
      input kind_t kind, input logic [63:0] op1, input logic [63:0] op2,
      input logic lus, input logic [31:0] bc);
      vec_t r;
      r.st = st; r.fl = fl; r.v = v; r.pc = pc;
      r.rs1 = rs1; r.rd1 = rd1; r.rs2 = rs2; r.rd2 = rd2;
      r.imm = imm; r.rd = rd; r.ctrl = ctrl;
      r.we = we; r.wrd = wrd; r.wdata = wdata;
      r.kind = kind; r.op1 = op1; r.op2 = op2; r.lus = lus; r.bc = bc;
      return r;
   endfunction

   function automatic logic [EW-1:0] actual();
      return {ex_valid, ex_ctrl, ex_pc, ex_op1, ex_op2, ex_imm,
              ex_rs1, ex_rs2, ex_rd, bubble_count};
   endfunction

   // Driver.
   task automatic drive(input vec_t t);
      stall = t.st; flush = t.fl; id_valid = t.v; id_pc = t.pc;
      id_rs1 = t.rs1; id_read_data1 = t.rd1; id_rs2 = t.rs2;
      id_read_data2 = t.rd2; id_imm = t.imm; id_rd = t.rd; id_ctrl = t.ctrl;
      wb_reg_write = t.we; wb_rd = t.wrd; wb_data = t.wdata;
   endtask

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: pop the oldest expectation and compare all EX outputs.
   task automatic check_out(input string name);
      logic [EW-1:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: no expected entry queued", name);
      end else begin
         e = exp_q.pop_front();
         if (actual() !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual(), e);
         end
      end
   endtask

   initial begin
      logic [EW-1:0] e;
      // Stimulus table: inputs, then kind / op1 / op2 / load_use_stall / count.
      //           st   fl   v    pc     rs1    rd1    rs2    rd2    imm    rd     ctrl   we   wrd    wdata
      tv[0]  = row(1'b0,1'b0,1'b1,'h100,5'd3, 'h4,  5'd2, 'h9,  'h10,5'd1, 8'h21,1'b0,5'd0, 'h0,   K_LD,  'h4,   'h9, 1'b0,0);
      tv[1]  = row(1'b0,1'b0,1'b1,'h104,5'd8, 'h11, 5'd5, 'h6,  'h14,5'd2, 8'h01,1'b1,5'd5, 'hAA,  K_LD,  'h11,  'hAA,1'b0,0);
      tv[2]  = row(1'b0,1'b0,1'b1,'h108,5'd8, 'h11, 5'd5, 'h6,  'h18,5'd2, 8'h01,1'b1,5'd6, 'hAA,  K_LD,  'h11,  'h6, 1'b0,0);
      tv[3]  = row(1'b0,1'b0,1'b1,'h10C,5'd9, 'h1,  5'd9, 'h2,  'h1C,5'd7, 8'h03,1'b1,5'd9, 'h55,  K_LD,  'h55,  'h55,1'b0,0);
      tv[4]  = row(1'b0,1'b0,1'b1,'h110,5'd7, 'h70, 5'd4, 'h40, 'h20,5'd3, 8'h01,1'b1,5'd7, 'h77,  K_BUB, 'h0,   'h0, 1'b1,1);
      tv[5]  = row(1'b0,1'b0,1'b1,'h110,5'd7, 'h70, 5'd4, 'h40, 'h20,5'd3, 8'h01,1'b0,5'd0, 'h0,   K_LD,  'h70,  'h40,1'b0,1);
      tv[6]  = row(1'b0,1'b0,1'b1,'h114,5'd0, 'h10, 5'd2, 'h20, 'h24,5'd0, 8'h02,1'b1,5'd0, 'hDEAD,K_LD,  'hDEAD,'h20,1'b0,1);
      tv[7]  = row(1'b0,1'b0,1'b1,'h118,5'd5, 'h50, 5'd0, 'h60, 'h28,5'd4, 8'h01,1'b0,5'd0, 'h0,   K_BUB, 'h0,   'h0, 1'b1,2);
      tv[8]  = row(1'b0,1'b0,1'b0,'h11C,5'd5, 'h33, 5'd6, 'h44, 'h2C,5'd5, 8'h21,1'b0,5'd0, 'h0,   K_LD,  'h33,  'h44,1'b0,2);
      tv[9]  = row(1'b0,1'b1,1'b0,'h120,5'd1, 'h1,  5'd1, 'h1,  'h30,5'd1, 8'h21,1'b0,5'd0, 'h0,   K_BUB, 'h0,   'h0, 1'b0,3);
      tv[10] = row(1'b0,1'b0,1'b1,'h124,5'd10,'h1,  5'd11,'h2,  'h34,5'd12,8'h02,1'b0,5'd0, 'h0,   K_LD,  'h1,   'h2, 1'b0,3);
      tv[11] = row(1'b1,1'b1,1'b1,'h128,5'd12,'h5,  5'd13,'h6,  'h38,5'd1, 8'h01,1'b0,5'd0, 'h0,   K_BUB, 'h0,   'h0, 1'b1,4);
      tv[12] = row(1'b0,1'b0,1'b1,'h12C,5'd1, 'hC0, 5'd2, 'hC1, 'h3C,5'd13,8'h21,1'b0,5'd0, 'h0,   K_LD,  'hC0,  'hC1,1'b0,4);
      tv[13] = row(1'b1,1'b0,1'b1,'h130,5'd1, 'hF1, 5'd2, 'hF2, 'h40,5'd3, 8'h01,1'b1,5'd1, 'hBB,  K_HOLD,'h0,   'h0, 1'b0,4);
      tv[14] = row(1'b1,1'b0,1'b1,'h134,5'd2, 'hF3, 5'd1, 'hF4, 'h41,5'd4, 8'h11,1'b1,5'd2, 'hBC,  K_HOLD,'h0,   'h0, 1'b0,4);
      tv[15] = row(1'b1,1'b0,1'b0,'h138,5'd3, 'hF5, 5'd4, 'hF6, 'h42,5'd5, 8'hFF,1'b0,5'd0, 'h0,   K_HOLD,'h0,   'h0, 1'b0,4);
      tv[16] = row(1'b0,1'b0,1'b1,'h140,5'd3, 'h7,  5'd4, 'h8,  'h44,5'd14,8'h02,1'b0,5'd0, 'h0,   K_LD,  'h7,   'h8, 1'b0,4);
      tv[17] = row(1'b1,1'b0,1'b1,'h144,5'd14,'h9,  5'd15,'hA,  'h48,5'd2, 8'h01,1'b1,5'd14,'hCC,  K_HOLD,'h0,   'h0, 1'b1,4);
      tv[18] = row(1'b0,1'b0,1'b1,'h144,5'd14,'h9,  5'd15,'hA,  'h48,5'd2, 8'h01,1'b0,5'd0, 'h0,   K_BUB, 'h0,   'h0, 1'b1,5);
      tv[19] = row(1'b0,1'b0,1'b1,'h148,5'd6, 'h12, 5'd7, 'h13, 'h4C,5'd9, 8'h01,1'b0,5'd0, 'h0,   K_LD,  'h12,  'h13,1'b0,5);

      // Reset block: everything cleared before any clock edge.
      reset = 1'b0;
      drive(row(1'b0,1'b0,1'b0,'h0,5'd0,'h0,5'd0,'h0,'h0,5'd0,8'h00,1'b0,5'd0,'h0,K_LD,'h0,'h0,1'b0,0));
      #3;
      check("reset_outputs", {44'h0, actual()} == '0 ? 64'd0 : 64'd1, 64'd0);
      check("reset_lus", {63'h0, load_use_stall}, 64'd0);
      #9 reset = 1'b1;
      last_exp = '0;
      @(posedge clk); #1;

      // Table-driven vectors.
      for (int i = 0; i < NV; i++) begin
         drive(tv[i]);
         #1;
         check($sformatf("lus_v%0d", i), {63'h0, load_use_stall}, {63'h0, tv[i].lus});
         case (tv[i].kind)
            K_LD:    e = {tv[i].v, (tv[i].v ? tv[i].ctrl : 8'h00), tv[i].pc,
                          tv[i].op1, tv[i].op2, tv[i].imm, tv[i].rs1,
                          tv[i].rs2, tv[i].rd, tv[i].bc};
            K_BUB:   e = {280'h0, tv[i].bc};
            default: e = last_exp;
         endcase
         exp_q.push_back(e);
         last_exp = e;
         @(posedge clk); #1;
         check_out($sformatf("ex_v%0d", i));
      end

      // Async reset mid-stall: EX holds a valid instruction, reset drops
      // between edges and must clear it without a clock.
      drive(tv[19]);
      stall = 1'b1;
      @(posedge clk); #1;
      check("hold_before_reset", {63'h0, ex_valid}, 64'd1);
      #2 reset = 1'b0;
      #1;
      check("async_valid", {63'h0, ex_valid}, 64'd0);
      check("async_count", {32'h0, bubble_count}, 64'd0);
      check("async_op1", ex_op1, 64'd0);
      check("async_lus", {63'h0, load_use_stall}, 64'd0);
      @(posedge clk); #1;
      check("reset_held_valid", {63'h0, ex_valid}, 64'd0);
      reset = 1'b1;
      stall = 1'b0;
      @(posedge clk); #1;
      check("resume_valid", {63'h0, ex_valid}, 64'd1);
      check("resume_op1", ex_op1, 64'h12);
      check("resume_rd", {59'h0, ex_rd}, 64'd9);

      // Saturation: preload the counter near the top, then flush twice.
      stall = 1'b1;
      force dut.bubble_count = 32'hFFFF_FFFE;
      #1 release dut.bubble_count;
      #1;
      stall = 1'b0;
      flush = 1'b1;
      @(posedge clk); #1;
      check("sat_first", {32'h0, bubble_count}, 64'hFFFF_FFFF);
      check("sat_flush_valid", {63'h0, ex_valid}, 64'd0);
      @(posedge clk); #1;
      check("sat_second", {32'h0, bubble_count}, 64'hFFFF_FFFF);
      flush = 1'b0;

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
